// File: rtl/qblock_pkg.sv
// Shared types and constants for the question-block tile controller.
package qblock_pkg;

  // Block life cycle: flashing, bumping up, bumping down, spent.
  typedef enum logic [1:0] {
    ANIM      = 2'd0,
    BUMP_UP   = 2'd1,
    BUMP_DOWN = 2'd2,
    EMPTY     = 2'd3
  } state_t;

  // Sprite ROM selector driving the renderer's colour mux.
  typedef enum logic [1:0] {
    SPR_Q0    = 2'd0,
    SPR_Q1    = 2'd1,
    SPR_Q2    = 2'd2,
    SPR_EMPTY = 2'd3
  } sprite_t;

  // Idle flash ping-pongs through the three Q frames.
  localparam sprite_t ANIM_SEQ [4] = '{SPR_Q0, SPR_Q1, SPR_Q2, SPR_Q1};

  // Map an animation step to the sprite frame shown for it.
  function automatic sprite_t frame_of(input logic [1:0] idx);
    return ANIM_SEQ[idx];
  endfunction

endpackage

// File: rtl/tile_addr_gen.sv
// Turns an in-tile pixel offset into a registered sprite-ROM address,
// range-checks it against the tile size and registers the sprite id
// alongside so both reach the ROM/mux in the same cycle.
module tile_addr_gen #(
  parameter int TILE_W = 20,
  parameter int TILE_H = 20,
  parameter int ADDR_W = 9,
  parameter int OFF_W  = 5
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              draw_en,
  input  logic [OFF_W-1:0]  x_off,
  input  logic [OFF_W-1:0]  y_off,
  input  logic [1:0]        sprite_in,
  output logic [ADDR_W-1:0] read_address,
  output logic [1:0]        sprite_sel,
  output logic              pix_valid
);

  logic              in_tile;
  logic [ADDR_W-1:0] addr_calc;

  // Row-major address; evaluated at full ROM width so in-range offsets never truncate.
  always_comb begin
    in_tile   = draw_en && (32'(x_off) < TILE_W) && (32'(y_off) < TILE_H);
    addr_calc = ADDR_W'(y_off) * ADDR_W'(TILE_W) + ADDR_W'(x_off);
  end

  // Output register: refreshed every cycle, address forced to 0 when off-tile.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      read_address <= '0;
      sprite_sel   <= '0;
      pix_valid    <= 1'b0;
    end else begin
      read_address <= in_tile ? addr_calc : '0;
      sprite_sel   <= sprite_in;
      pix_valid    <= in_tile;
    end
  end

endmodule

// File: rtl/qblock_ctrl.sv
// Question-block tile controller: idle flash animation, hit acceptance with
// coin spawn, bump-up/bump-down offset, then a terminal empty block.
module qblock_ctrl
  import qblock_pkg::*;
#(
  parameter int FRAME_HOLD  = 8,
  parameter int BUMP_HEIGHT = 4,
  parameter int TILE_W      = 20,
  parameter int TILE_H      = 20,
  parameter int ADDR_W      = 9
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_tick,
  input  logic              hit,
  input  logic              draw_en,
  input  logic [4:0]        x_off,
  input  logic [4:0]        y_off,
  output logic [ADDR_W-1:0] read_address,
  output logic [1:0]        sprite_sel,
  output logic              pix_valid,
  output logic [3:0]        y_bump,
  output logic              coin_spawn,
  output logic              is_empty
);

  localparam logic [7:0] HOLD_LAST = 8'(FRAME_HOLD - 1);
  localparam logic [3:0] BUMP_TOP  = 4'(BUMP_HEIGHT);

  state_t     state_reg,    state_next;
  logic [1:0] anim_idx_reg, anim_idx_next;
  logic [7:0] hold_cnt_reg, hold_cnt_next;
  logic [3:0] y_bump_reg,   y_bump_next;
  logic       coin_reg,     coin_next;
  sprite_t    sprite_cur;

  // State and counter registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg    <= ANIM;
      anim_idx_reg <= 2'd0;
      hold_cnt_reg <= 8'd0;
      y_bump_reg   <= 4'd0;
      coin_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      anim_idx_reg <= anim_idx_next;
      hold_cnt_reg <= hold_cnt_next;
      y_bump_reg   <= y_bump_next;
      coin_reg     <= coin_next;
    end
  end

  // Next-state logic; a hit outranks a coincident tick, which is then dropped.
  always_comb begin
    state_next    = state_reg;
    anim_idx_next = anim_idx_reg;
    hold_cnt_next = hold_cnt_reg;
    y_bump_next   = y_bump_reg;
    coin_next     = 1'b0;
    case (state_reg)
      ANIM: begin
        if (hit) begin
          state_next = BUMP_UP;
          coin_next  = 1'b1;
        end else if (frame_tick) begin
          if (hold_cnt_reg >= HOLD_LAST) begin
            hold_cnt_next = 8'd0;
            anim_idx_next = anim_idx_reg + 2'd1;
          end else begin
            hold_cnt_next = hold_cnt_reg + 8'd1;
          end
        end
      end
      BUMP_UP: begin
        if (frame_tick) begin
          y_bump_next = y_bump_reg + 4'd1;
          if (y_bump_reg + 4'd1 >= BUMP_TOP) state_next = BUMP_DOWN;
        end
      end
      BUMP_DOWN: begin
        if (frame_tick) begin
          if (y_bump_reg <= 4'd1) begin
            y_bump_next = 4'd0;
            state_next  = EMPTY;
          end else begin
            y_bump_next = y_bump_reg - 4'd1;
          end
        end
      end
      EMPTY: begin
        y_bump_next = 4'd0;
      end
      default: begin
        state_next = ANIM;
      end
    endcase
  end

  // Sprite shown this cycle: flash frame while idle, empty block once hit.
  always_comb begin
    sprite_cur = (state_reg == ANIM) ? frame_of(anim_idx_reg) : SPR_EMPTY;
  end

  tile_addr_gen #(
    .TILE_W (TILE_W),
    .TILE_H (TILE_H),
    .ADDR_W (ADDR_W),
    .OFF_W  (5)
  ) u_addr (
    .Clk          (Clk),
    .Reset        (Reset),
    .draw_en      (draw_en),
    .x_off        (x_off),
    .y_off        (y_off),
    .sprite_in    (sprite_cur),
    .read_address (read_address),
    .sprite_sel   (sprite_sel),
    .pix_valid    (pix_valid)
  );

  assign y_bump     = y_bump_reg;
  assign coin_spawn = coin_reg;
  assign is_empty   = (state_reg != ANIM);

endmodule

// File: tb/tb_qblock_ctrl.sv
// Directed bench for qblock_ctrl: animation timing, address path, hit/bump
// sequence, ignored hits and asynchronous reset recovery.
module tb_qblock_ctrl;

  logic       Clk;
  logic       Reset;
  logic       frame_tick;
  logic       hit;
  logic       draw_en;
  logic [4:0] x_off;
  logic [4:0] y_off;
  logic [8:0] read_address;
  logic [1:0] sprite_sel;
  logic       pix_valid;
  logic [3:0] y_bump;
  logic       coin_spawn;
  logic       is_empty;

  int n_checks = 0;
  int n_pass   = 0;

  qblock_ctrl #(
    .FRAME_HOLD  (8),
    .BUMP_HEIGHT (4),
    .TILE_W      (20),
    .TILE_H      (20),
    .ADDR_W      (9)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .frame_tick   (frame_tick),
    .hit          (hit),
    .draw_en      (draw_en),
    .x_off        (x_off),
    .y_off        (y_off),
    .read_address (read_address),
    .sprite_sel   (sprite_sel),
    .pix_valid    (pix_valid),
    .y_bump       (y_bump),
    .coin_spawn   (coin_spawn),
    .is_empty     (is_empty)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Single comparison point; one line per check.
  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) begin
      n_pass++;
      $display("ok   %-18s obs=%0d exp=%0d", tag, obs, exp);
    end else begin
      $display("FAIL %-18s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  // One-cycle tick, then one idle cycle so registered outputs have settled.
  task automatic pulse_tick();
    frame_tick = 1'b1;
    @(negedge Clk);
    frame_tick = 1'b0;
    @(negedge Clk);
  endtask

  // One-cycle hit; returns at the negedge right after the sampling edge.
  task automatic pulse_hit();
    hit = 1'b1;
    @(negedge Clk);
    hit = 1'b0;
  endtask

  // Apply offsets, let one edge register them.
  task automatic addr_vec(input logic de, input int x, input int y,
                          input int exp_addr, input int exp_valid);
    draw_en = de;
    x_off   = 5'(x);
    y_off   = 5'(y);
    @(negedge Clk);
    check($sformatf("addr(%0d,%0d)", x, y), int'(read_address), exp_addr);
    check($sformatf("valid(%0d,%0d)", x, y), int'(pix_valid), exp_valid);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_y [8] = '{1, 2, 3, 4, 3, 2, 1, 0};

    Reset = 1'b1; frame_tick = 1'b0; hit = 1'b0;
    draw_en = 1'b0; x_off = 5'd0; y_off = 5'd0;
    repeat (2) @(negedge Clk);
    check("rst_addr",   int'(read_address), 0);
    check("rst_sprite", int'(sprite_sel), 0);
    check("rst_valid",  int'(pix_valid), 0);
    check("rst_ybump",  int'(y_bump), 0);
    check("rst_coin",   int'(coin_spawn), 0);
    check("rst_empty",  int'(is_empty), 0);
    Reset = 1'b0;
    @(negedge Clk);

    // Idle flash: frame advances every 8 ticks through 0,1,2,1,0.
    for (int i = 1; i <= 32; i++) begin
      pulse_tick();
      if (i == 1 || i == 7) check($sformatf("anim_t%0d", i), int'(sprite_sel), 0);
      if (i == 8 || i == 15) check($sformatf("anim_t%0d", i), int'(sprite_sel), 1);
      if (i == 16) check("anim_t16", int'(sprite_sel), 2);
      if (i == 24) check("anim_t24", int'(sprite_sel), 1);
      if (i == 32) check("anim_t32", int'(sprite_sel), 0);
    end

    // Address path including tile edges and disabled draw.
    addr_vec(1'b1, 7, 3, 67, 1);
    addr_vec(1'b1, 20, 3, 0, 0);
    addr_vec(1'b1, 19, 19, 399, 1);
    addr_vec(1'b1, 0, 20, 0, 0);
    addr_vec(1'b1, 0, 0, 0, 1);
    addr_vec(1'b0, 5, 1, 0, 0);

    // Bring hold count to 7, then hit with a coincident tick.
    for (int i = 0; i < 7; i++) pulse_tick();
    check("pre_hit_sprite", int'(sprite_sel), 0);
    frame_tick = 1'b1;
    pulse_hit();
    frame_tick = 1'b0;
    check("hit_coin",  int'(coin_spawn), 1);
    check("hit_empty", int'(is_empty), 1);
    check("hit_ybump", int'(y_bump), 0);
    @(negedge Clk);
    check("coin_1clk",  int'(coin_spawn), 0);
    check("hit_sprite", int'(sprite_sel), 3);

    // Bump 1,2,3,4,3,2,1,0 with a stray hit in BUMP_DOWN.
    for (int i = 0; i < 8; i++) begin
      pulse_tick();
      check($sformatf("bump_t%0d", i + 1), int'(y_bump), exp_y[i]);
      if (i == 4) begin
        pulse_hit();
        check("hit_down_coin", int'(coin_spawn), 0);
        check("hit_down_ybump", int'(y_bump), 3);
      end
    end

    // EMPTY is terminal and ignores hits and ticks.
    pulse_hit();
    check("hit_empty_coin", int'(coin_spawn), 0);
    pulse_tick();
    check("empty_ybump",  int'(y_bump), 0);
    check("empty_flag",   int'(is_empty), 1);
    check("empty_sprite", int'(sprite_sel), 3);

    // Async reset mid-bump, then a fresh hit spawns a coin again.
    Reset = 1'b1;
    #2;
    Reset = 1'b0;
    @(negedge Clk);
    pulse_hit();
    check("rehit_coin", int'(coin_spawn), 1);
    for (int i = 0; i < 3; i++) pulse_tick();
    check("mid_ybump", int'(y_bump), 3);
    draw_en = 1'b1; x_off = 5'd2; y_off = 5'd1;
    @(negedge Clk);
    check("mid_addr", int'(read_address), 22);
    #2;
    Reset = 1'b1;
    #1;
    check("async_ybump",  int'(y_bump), 0);
    check("async_empty",  int'(is_empty), 0);
    check("async_addr",   int'(read_address), 0);
    check("async_valid",  int'(pix_valid), 0);
    check("async_sprite", int'(sprite_sel), 0);
    check("async_coin",   int'(coin_spawn), 0);
    #1;
    Reset = 1'b0;
    draw_en = 1'b0;
    @(negedge Clk);
    pulse_hit();
    check("post_rst_coin",  int'(coin_spawn), 1);
    check("post_rst_empty", int'(is_empty), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
